// File: rtl/sha3_axil_pkg.sv
// Shared definitions for the SHA3 AXI4-Lite register front end.
// Register word offsets, response codes, bit positions, FSM state encodings.
// The message stream payload is carried as a packed struct.
package sha3_axil_pkg;

    // Word index taken from addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIN    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DOUT   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // CTRL bit positions
    localparam int CTRL_START    = 0;
    localparam int CTRL_LAST_ARM = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // STATUS bit positions
    localparam int STAT_BUF_FULL  = 0;
    localparam int STAT_DIG_AVAIL = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_IRQ_PEND  = 3;
    localparam int STAT_WR_LSB    = 8;
    localparam int WORDS_W        = 4;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } msg_t;

    typedef enum logic [1:0] {
        WR_IDLE     = 2'd0,
        WR_WAIT_BUF = 2'd1,
        WR_RESP     = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sha3_axil_skid.sv
// Purpose: one-entry valid/ready holding register between register writes and the core.
// Latency: one cycle from accepted push to out_vld.
// Backpressure: in_rdy when empty or when the held entry drains this cycle (push+pop both honoured).
module sha3_axil_skid #(
    parameter int W = 33
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    assign in_rdy = !out_vld || out_rdy;

    // Hold one entry; refill in the same cycle the old one leaves.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/sha3_axil_slave.sv
// Purpose: AXI4-Lite register slave feeding message words to the SHA3 core and reading digest words back; optional IRQ under `SHA3_AXIL_IRQ_EN`.
// Latency: write response 1 cycle after AW+W (more while a DIN waits for buffer space); read data 1 cycle after AR.
// Backpressure: DIN writes stall the B channel while the message buffer is full; B and R hold until bready/rready.
module sha3_axil_slave
    import sha3_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DOUT_WORDS         = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                      s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     msg_data,
    output logic                            msg_last,
    output logic                            msg_valid,
    input  logic                            msg_ready,
    input  logic [31:0]                     dig_data,
    input  logic                            dig_valid,
    output logic                            dig_ready,
`ifdef SHA3_AXIL_IRQ_EN
    output logic                            irq,
`endif
    output logic                            core_start
);

    wr_state_t              wr_state;
    rd_state_t              rd_state;
    logic [31:0]            ctrl_reg;
    logic [31:0]            din_hold;
    logic                   busy;
    logic [WORDS_W-1:0]     words_read;
    logic [1:0]             wr_idx, rd_idx;
    logic                   wr_hs, rd_hs, start_req, dig_pop;
    logic                   push_vld, push_rdy;
    msg_t                   push_dat, buf_dat;
    logic [31:0]            rd_val;
    logic                   rd_err;
    logic                   irq_pend;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign wr_idx    = s00_axi_awaddr[3:2];
    assign rd_idx    = s00_axi_araddr[3:2];
    assign wr_hs     = s00_axi_awready && s00_axi_wready && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_hs     = s00_axi_arready && s00_axi_arvalid;
    assign start_req = wr_hs && (wr_idx == REG_CTRL) && s00_axi_wstrb[0]
                       && s00_axi_wdata[CTRL_START] && !busy;
    assign dig_pop   = rd_hs && (rd_idx == REG_DOUT) && dig_valid;
    assign dig_ready = dig_pop;

    // A DIN word goes straight into the buffer when it has room, otherwise from the hold register.
    assign push_vld      = (wr_hs && (wr_idx == REG_DIN)) || (wr_state == WR_WAIT_BUF);
    assign push_dat.last = ctrl_reg[CTRL_LAST_ARM];
    assign push_dat.data = (wr_state == WR_WAIT_BUF) ? din_hold : s00_axi_wdata;

    sha3_axil_skid #(.W($bits(msg_t))) u_skid (
        .core_clk (s00_axi_aclk),
        .arst_n   (s00_axi_aresetn),
        .in_vld   (push_vld),
        .in_rdy   (push_rdy),
        .in_dat   (push_dat),
        .out_vld  (msg_valid),
        .out_rdy  (msg_ready),
        .out_dat  (buf_dat)
    );
    assign msg_data = buf_dat.data;
    assign msg_last = buf_dat.last;

    // Write FSM: joint AW+W accept, register update, DIN push, B response.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_state        <= WR_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            ctrl_reg        <= '0;
            din_hold        <= '0;
            core_start      <= 1'b0;
        end else begin
            core_start <= start_req;
            if (push_vld && push_rdy) ctrl_reg[CTRL_LAST_ARM] <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    s00_axi_awready <= 1'b1;
                    s00_axi_wready  <= 1'b1;
                    if (wr_hs) begin
                        s00_axi_awready <= 1'b0;
                        s00_axi_wready  <= 1'b0;
                        s00_axi_bresp   <= RESP_OKAY;
                        wr_state        <= WR_RESP;
                        s00_axi_bvalid  <= 1'b1;
                        case (wr_idx)
                            REG_CTRL: begin
                                for (int b = 0; b < 4; b++)
                                    if (s00_axi_wstrb[b]) ctrl_reg[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                                ctrl_reg[CTRL_START] <= 1'b0;
                            end
                            REG_DIN: begin
                                din_hold <= s00_axi_wdata;
                                if (!push_rdy) begin
                                    wr_state       <= WR_WAIT_BUF;
                                    s00_axi_bvalid <= 1'b0;
                                end
                            end
`ifdef SHA3_AXIL_IRQ_EN
                            REG_STATUS: s00_axi_bresp <= RESP_OKAY;
`else
                            REG_STATUS: s00_axi_bresp <= RESP_SLVERR;
`endif
                            default:    s00_axi_bresp <= RESP_SLVERR;
                        endcase
                    end
                end
                WR_WAIT_BUF: begin
                    if (push_rdy) begin
                        wr_state       <= WR_RESP;
                        s00_axi_bvalid <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (s00_axi_bready) begin
                        wr_state        <= WR_IDLE;
                        s00_axi_bvalid  <= 1'b0;
                        s00_axi_awready <= 1'b1;
                        s00_axi_wready  <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (rd_idx)
            REG_CTRL:   rd_val = ctrl_reg;
            REG_DIN:    rd_val = '0;
            REG_STATUS: begin
                rd_val[STAT_BUF_FULL]              = msg_valid;
                rd_val[STAT_DIG_AVAIL]             = dig_valid;
                rd_val[STAT_BUSY]                  = busy;
                rd_val[STAT_IRQ_PEND]              = irq_pend;
                rd_val[STAT_WR_LSB +: WORDS_W]     = words_read;
            end
            default: begin
                if (dig_valid) rd_val = dig_data;
                else           rd_err = 1'b1;
            end
        endcase
    end

    // Read FSM: registered data one cycle after AR, held until rready.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_state        <= RD_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rresp   <= RESP_OKAY;
            s00_axi_rdata   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    s00_axi_arready <= 1'b1;
                    if (rd_hs) begin
                        s00_axi_arready <= 1'b0;
                        s00_axi_rvalid  <= 1'b1;
                        s00_axi_rdata   <= rd_val;
                        s00_axi_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rd_state        <= RD_RESP;
                    end
                end
                default: begin
                    if (s00_axi_rready) begin
                        s00_axi_rvalid  <= 1'b0;
                        s00_axi_arready <= 1'b1;
                        rd_state        <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Hash progress: busy from START until the last digest word is popped.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            busy       <= 1'b0;
            words_read <= '0;
        end else begin
            if (start_req) busy <= 1'b1;
            if (dig_pop) begin
                if (words_read == WORDS_W'(DOUT_WORDS - 1)) begin
                    words_read <= '0;
                    busy       <= 1'b0;
                end else begin
                    words_read <= words_read + 1'b1;
                end
            end
        end
    end

`ifdef SHA3_AXIL_IRQ_EN
    logic dig_valid_q;
    logic irq_w1c;
    assign irq_w1c = wr_hs && (wr_idx == REG_STATUS) && s00_axi_wstrb[0]
                     && s00_axi_wdata[STAT_IRQ_PEND];

    // Pending flag latches a new digest; software clears it by writing 1.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            dig_valid_q <= 1'b0;
            irq_pend    <= 1'b0;
            irq         <= 1'b0;
        end else begin
            dig_valid_q <= dig_valid;
            if (dig_valid && !dig_valid_q) irq_pend <= 1'b1;
            else if (irq_w1c)              irq_pend <= 1'b0;
            irq <= irq_pend && ctrl_reg[CTRL_IRQ_EN];
        end
    end
`else
    assign irq_pend = 1'b0;
`endif

endmodule

// File: tb/tb_sha3_axil_slave.sv
// Purpose: directed checks of the SHA3 AXI4-Lite front end (register table plus stream/reset sequences).
// Latency: drives on posedge+1, samples on negedge.
// Backpressure: toggles msg_ready and bready to exercise stalled responses.
module tb_sha3_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, msg_data, dig_data;
    logic        msg_last, msg_valid, msg_ready = 1'b1;
    logic        dig_valid, dig_ready, dig_en = 1'b0, core_start;
`ifdef SHA3_AXIL_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int dig_idx = 0;
    int msg_cnt = 0, start_cnt = 0, bv_cnt = 0;
    logic [32:0] msg_log [16];

    always #5 clk = ~clk;

    sha3_axil_slave dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .msg_data(msg_data), .msg_last(msg_last),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_ready(dig_ready),
`ifdef SHA3_AXIL_IRQ_EN
        .irq(irq),
`endif
        .core_start(core_start)
    );

    // Core digest model: eight words 0x10..0x17, advancing after each pop.
    assign dig_valid = dig_en && (dig_idx < 8);
    assign dig_data  = 32'h10 + 32'(dig_idx);
    always begin
        @(negedge clk);
        if (dig_valid && dig_ready) begin
            @(posedge clk);
            #1 dig_idx = dig_idx + 1;
        end
    end

    // Stream/pulse monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && msg_valid && msg_ready && msg_cnt < 16) begin
            msg_log[msg_cnt] = {msg_last, msg_data};
            msg_cnt = msg_cnt + 1;
        end
        if (core_start) start_cnt = start_cnt + 1;
        if (bvalid) bv_cnt = bv_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!(awready && wready) && t < 50) begin @(negedge clk); t++; end
        chk("aw_w_accept", {63'b0, awready && wready}, 64'd1);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wr_wait_b(output logic [1:0] r);
        int t = 0;
        @(negedge clk);
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        chk("b_valid", {63'b0, bvalid}, 64'd1);
        r = bresp;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        wr_issue(a, d, s);
        wr_wait_b(r);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        int t = 0;
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        chk("ar_accept", {63'b0, arready}, 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        chk("r_valid", {63'b0, rvalid}, 64'd1);
        d = rdata; r = rresp;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] out_vec();
        return {18'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp,
                dig_ready, core_start, msg_last, msg_valid, rdata | msg_data};
    endfunction

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;
`ifdef SHA3_AXIL_IRQ_EN
    localparam logic [1:0] STAT_WR_RESP = OK;
`else
    localparam logic [1:0] STAT_WR_RESP = ERR;
`endif

    initial begin
        vec_t        vt [11];
        logic [31:0] d;
        logic [1:0]  r;
        int          base;

        vt[0]  = '{1'b1, 4'h0, 32'h0000_0002, 4'hF, 32'h0,         OK};
        vt[1]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0002, OK};
        vt[2]  = '{1'b1, 4'h0, 32'hFFFF_FF00, 4'h2, 32'h0,         OK};
        vt[3]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_FF02, OK};
        vt[4]  = '{1'b1, 4'h0, 32'h0,         4'hF, 32'h0,         OK};
        vt[5]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0,         OK};
        vt[6]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0,         OK};
        vt[7]  = '{1'b1, 4'h8, 32'h0,         4'hF, 32'h0,         STAT_WR_RESP};
        vt[8]  = '{1'b1, 4'hC, 32'h0,         4'hF, 32'h0,         ERR};
        vt[9]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0,         ERR};
        vt[10] = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0,         OK};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(2);

        // Register table
        foreach (vt[i]) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), {62'b0, r}, {62'b0, vt[i].exp_resp});
            end else begin
                axi_read(vt[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), {32'b0, d}, {32'b0, vt[i].exp_data});
                chk($sformatf("vec%0d_rresp", i), {62'b0, r}, {62'b0, vt[i].exp_resp});
            end
        end

        // START pulse: exactly one cycle, bit self-clears, busy sets
        base = start_cnt;
        axi_write(4'h0, 32'h3, 4'hF, r);
        cycles(3);
        chk("start_pulse_cycles", 64'(start_cnt - base), 64'd1);
        axi_read(4'h0, d, r);
        chk("ctrl_after_start", {32'b0, d}, 64'h2);
        axi_read(4'h8, d, r);
        chk("status_busy", {32'b0, d}, 64'h4);
        axi_write(4'h0, 32'h0, 4'hF, r);

        // DIN with stalled core: second response withheld until msg_ready
        msg_ready = 1'b0;
        base = msg_cnt;
        axi_write(4'h4, 32'hA5A5_A5A5, 4'hF, r);
        chk("din1_bresp", {62'b0, r}, 64'd0);
        wr_issue(4'h4, 32'h1234_5678, 4'hF);
        bv_cnt = 0;
        axi_read(4'h8, d, r);
        chk("status_buf_full", {32'b0, d}, 64'h5);
        cycles(3);
        chk("din2_bvalid_held", 64'(bv_cnt), 64'd0);
        msg_ready = 1'b1;
        wr_wait_b(r);
        chk("din2_bresp", {62'b0, r}, 64'd0);
        cycles(3);
        chk("msg_count", 64'(msg_cnt - base), 64'd2);
        chk("msg_word0", {31'b0, msg_log[base]},     {31'b0, 1'b0, 32'hA5A5_A5A5});
        chk("msg_word1", {31'b0, msg_log[base + 1]}, {31'b0, 1'b0, 32'h1234_5678});

        // LAST_ARM tags the next word and clears itself
        axi_write(4'h0, 32'h2, 4'hF, r);
        axi_write(4'h4, 32'hDEAD_BEEF, 4'hF, r);
        cycles(3);
        chk("msg_last_word", {31'b0, msg_log[base + 2]}, {31'b0, 1'b1, 32'hDEAD_BEEF});
        axi_read(4'h0, d, r);
        chk("ctrl_last_cleared", {32'b0, d}, 64'h0);

        // Digest readout: eight words, counter and busy
        dig_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            axi_read(4'hC, d, r);
            chk($sformatf("dout%0d_data", i), {32'b0, d}, 64'h10 + 64'(i));
            chk($sformatf("dout%0d_resp", i), {62'b0, r}, 64'd0);
            if (i == 2) begin
                axi_read(4'h8, d, r);
                chk("status_mid_digest", {32'b0, d}, 64'h306);
            end
        end
        axi_read(4'h8, d, r);
        chk("status_after_digest", {32'b0, d}, 64'h0);
        axi_read(4'hC, d, r);
        chk("dout_empty_data", {32'b0, d}, 64'h0);
        chk("dout_empty_resp", {62'b0, r}, 64'h2);

        // Reset while a write response is pending and the buffer is full
        msg_ready = 1'b0;
        axi_write(4'h4, 32'hCAFE_F00D, 4'hF, r);
        bready = 1'b0;
        wr_issue(4'h0, 32'h0000_AB00, 4'hF);
        @(negedge clk);
        chk("pre_reset_pending", {62'b0, bvalid, msg_valid}, 64'h3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", out_vec(), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bready = 1'b1;
        msg_ready = 1'b1;
        cycles(3);
        axi_read(4'h0, d, r);
        chk("ctrl_after_reset", {32'b0, d}, 64'h0);
        axi_read(4'h8, d, r);
        chk("status_after_reset", {32'b0, d}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha3_axil_slave.md
Name: sha3_axil_slave

Overview:
- AXI4-Lite slave front end for the SHA3 core; the register target driven by the block-design AXI master.
- Converts register writes into a 32-bit message-word stream for the core, and core digest words into register reads.
- Exposes control/status to software; sits between the AXI interconnect and the sha3 core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 word registers.
- DOUT_WORDS, 8, digest words per hash (8 = 256-bit).

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; asynchronous, active-low
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes
- s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
- s00_axi_bresp  out  2  write response
- s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response
- s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
- msg_data  out  32  message word to core
- msg_last  out  1  final word of message
- msg_valid / msg_ready  out/in  1  message stream handshake
- dig_data  in  32  digest word from core
- dig_valid / dig_ready  in/out  1  digest stream handshake
- core_start  out  1  one-cycle start pulse

Behaviour:
- Reset is asynchronous and active-low on s00_axi_aresetn, single clock s00_axi_aclk. All outputs are 0 during reset: all ready/valid, bresp, rresp, rdata, msg_*, core_start.
- Register map uses addr[3:2]:
  - 0x0 CTRL RW. Bit0 START self-clears and pulses core_start for 1 cycle. Bit1 LAST_ARM. Bits[31:2] readback as stored.
  - 0x4 DIN WO. A write pushes wdata to the message buffer with msg_last=LAST_ARM; LAST_ARM auto-clears on the push. A read returns 0 with OKAY.
  - 0x8 STATUS RO: bit0 buf_full, bit1 dig_avail, bit2 busy, bits[11:8] words_read.
  - 0xC DOUT RO. A read pops one digest word.
- Write FSM, states IDLE -> WAIT_BUF -> RESP:
  - IDLE: awready and wready are both asserted. Accept only when AW and W are valid in the same cycle; no lone-channel acceptance.
  - DIN write with buffer full: go to WAIT_BUF and hold BVALID until the buffer drains, then push and go to RESP.
  - RESP: bvalid held until bready, then back to IDLE. bresp=SLVERR (2'b10) for writes to STATUS/DOUT, else OKAY.
  - wstrb applies per byte to CTRL. DIN ignores wstrb (full word).
- Read FSM, states IDLE -> RESP:
  - arready=1 in IDLE.
  - rdata is registered, giving 1-cycle latency from the AR handshake to rvalid; rvalid is held until rready.
  - DOUT read with dig_valid=0: returns 0, rresp=SLVERR, no pop.
  - DOUT read with dig_valid=1: dig_ready pulses 1 cycle at the AR handshake, and words_read increments.
  - words_read wraps to 0 after DOUT_WORDS pops.
- Message buffer is a 1-entry skid register. msg_valid stays set until msg_ready; a push and a pop in the same cycle are both honoured.
- busy sets on START and clears after DOUT_WORDS pops. START while busy is ignored; the write still returns OKAY.
- Simultaneous read and write are handled independently; the read sees the pre-write register value.
- Reset mid-transaction drops all pending transfers and clears the buffer and counters.

Optional Feature:
- Macro SHA3_AXIL_IRQ_EN.
- With it defined:
  - Adds output irq.
  - CTRL bit2 is IRQ_ENABLE.
  - STATUS bit3 is irq_pending, set on the dig_valid rising edge and cleared by writing 1 to STATUS bit3 (W1C exception to SLVERR, returns OKAY).
  - irq = irq_pending & IRQ_ENABLE, registered.
- Without it: no irq port, CTRL bit2 is plain storage, STATUS bit3 reads 0, and STATUS writes are SLVERR.

Decomposition:
- Package sha3_axil_pkg:
  - register offset constants REG_CTRL / REG_DIN / REG_STATUS / REG_DOUT;
  - resp constants RESP_OKAY / RESP_SLVERR;
  - CTRL/STATUS bit-index constants;
  - enum typedefs for write and read FSM states.
- Sub-module sha3_axil_skid: 1-entry valid/ready skid register, 33 bits wide (data + last).

Test Plan:
- Write CTRL=0x00000002, read CTRL -> 0x00000002, OKAY; START written as 0x3 -> core_start high exactly 1 cycle, readback 0x2.
- Write DIN=0xA5A5A5A5 with msg_ready=0, then write DIN=0x12345678 -> second bvalid withheld until msg_ready rises; words emitted in order, msg_last=0.
- Set LAST_ARM, write DIN=0xDEADBEEF -> msg_last=1 on that word; CTRL bit1 reads 0 afterwards.
- Core presents 8 digest words 0x10..0x17 -> 8 DOUT reads return 0x10..0x17, OKAY; STATUS busy=0 and words_read=0 after the 8th read.
- Read DOUT with dig_valid=0 -> rdata=0, rresp=2'b10; write STATUS -> bresp=2'b10.
- Deassert s00_axi_aresetn while bvalid is pending -> all outputs 0 asynchronously; after release, CTRL reads 0x0.
